// File: rtl/gg_deblock_pkg.sv
// Shared definitions for the deblocker output path.
// Contents:
//   ch_e        - channel index names for the NCH=4 deblocker outputs
//   BLK_SAMPLES - samples per 4x4 block
//   DROP_BITS   - width of the saturating drop counter
//   level_bits  - occupancy counter width for a given buffer depth
//   cnt_bits    - width able to hold 0..nch (popcount / offsets)
package gg_deblock_pkg;

  typedef enum logic [2:0] {
    CH_ALE = 3'd0,
    CH_ABV = 3'd1,
    CH_LEF = 3'd2,
    CH_CUR = 3'd3
  } ch_e;

  localparam int unsigned BLK_SAMPLES = 16;
  localparam int unsigned DROP_BITS   = 16;

  function automatic int unsigned level_bits(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int unsigned cnt_bits(input int unsigned nch);
    return $clog2(nch + 1);
  endfunction

endpackage

// File: rtl/gg_wb_compact.sv
// Combinational prefix popcount over a per-channel valid vector.
// Ports:
//   in_valid - per-channel valid, bit 0 is the oldest channel
//   offset   - per-channel write offset = number of valid channels below it
//   k        - total number of valid channels
module gg_wb_compact
  import gg_deblock_pkg::*;
#(
  parameter int unsigned NCH      = 4,
  parameter int unsigned CNT_BITS = cnt_bits(NCH)
) (
  input  logic [NCH-1:0]                in_valid,
  output logic [NCH-1:0][CNT_BITS-1:0]  offset,
  output logic [CNT_BITS-1:0]           k
);

  logic [CNT_BITS-1:0] acc;

  always_comb begin
    acc    = '0;
    offset = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      offset[i] = acc;
      acc       = acc + CNT_BITS'(in_valid[i]);
    end
    k = acc;
  end

endmodule

// File: rtl/gg_deblock_writeback.sv
// Output serialiser after the deblocker: compacts up to NCH valid blocks per
// cycle into a circular buffer and drains one block per cycle over
// ready/valid. Reports overflow rather than partially accepting a cycle.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   in_valid/data/tag   - NCH input channels (bit/slice 0 = oldest)
//   in_ready            - room for a full NCH-block cycle
//   out_valid/ready     - head handshake; out_data/out_tag = head entry
//   flush               - synchronous empty (status counters untouched)
//   ovf_clr             - clears overflow and drop_cnt
//   level               - current occupancy
//   overflow, drop_cnt  - sticky drop flag and saturating dropped-block count
module gg_deblock_writeback
  import gg_deblock_pkg::*;
#(
  parameter int unsigned NCH      = 4,
  parameter int unsigned PIX_BITS = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned TAG_BITS = 24
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NCH-1:0]                         in_valid,
  input  logic [NCH*BLK_SAMPLES*PIX_BITS-1:0]    in_data,
  input  logic [NCH*TAG_BITS-1:0]                in_tag,
  output logic                                   in_ready,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [BLK_SAMPLES*PIX_BITS-1:0]        out_data,
  output logic [TAG_BITS-1:0]                    out_tag,
  input  logic                                   flush,
  input  logic                                   ovf_clr,
  output logic [$clog2(DEPTH):0]                 level,
  output logic                                   overflow,
  output logic [DROP_BITS-1:0]                   drop_cnt
);

  localparam int unsigned PTR_BITS = $clog2(DEPTH);
  localparam int unsigned LVL_BITS = level_bits(DEPTH);
  localparam int unsigned CNT_BITS = cnt_bits(NCH);
  localparam int unsigned BLK_W    = BLK_SAMPLES * PIX_BITS;
  localparam logic [LVL_BITS-1:0] READY_MAX = LVL_BITS'(DEPTH - NCH);

  typedef logic [BLK_SAMPLES-1:0][PIX_BITS-1:0] block_t;

  block_t              data_mem [DEPTH];
  logic [TAG_BITS-1:0] tag_mem  [DEPTH];

  logic [PTR_BITS-1:0]               wr_ptr;
  logic [PTR_BITS-1:0]               rd_ptr;
  logic [NCH-1:0][CNT_BITS-1:0]      offset;
  logic [CNT_BITS-1:0]               k;
  logic                              any_valid;
  logic                              push;
  logic                              pop;
  logic                              drop;
  logic [DROP_BITS:0]                drop_sum;
  logic [DROP_BITS-1:0]              drop_sat;

  gg_wb_compact #(
    .NCH      (NCH),
    .CNT_BITS (CNT_BITS)
  ) u_compact (
    .in_valid (in_valid),
    .offset   (offset),
    .k        (k)
  );

  // Ready comes from the registered level so a cycle is all-or-nothing.
  assign in_ready  = (level <= READY_MAX);
  assign out_valid = (level != '0);
  assign any_valid = |in_valid;
  assign push      = any_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign drop      = any_valid && !in_ready;

  assign out_data  = data_mem[rd_ptr];
  assign out_tag   = tag_mem[rd_ptr];

  assign drop_sum  = {1'b0, drop_cnt} + (DROP_BITS+1)'(k);
  assign drop_sat  = drop_sum[DROP_BITS] ? '1 : drop_sum[DROP_BITS-1:0];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_BITS'(k);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_BITS'(1);
      end
      level <= level + (push ? LVL_BITS'(k) : '0) - LVL_BITS'(pop);
    end
  end

  // A drop in the same cycle as ovf_clr restarts the count at this cycle's k.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      drop_cnt <= ovf_clr ? DROP_BITS'(k) : drop_sat;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

  // Each valid channel lands at wr_ptr + (valid channels below it), so gaps
  // in in_valid collapse into consecutive entries.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (in_valid[i]) begin
          data_mem[wr_ptr + PTR_BITS'(offset[i])] <= in_data[i*BLK_W +: BLK_W];
          tag_mem[wr_ptr + PTR_BITS'(offset[i])]  <= in_tag[i*TAG_BITS +: TAG_BITS];
        end
      end
    end
  end

endmodule

// File: tb/tb_gg_deblock_writeback.sv
module tb_gg_deblock_writeback;
  import gg_deblock_pkg::*;

  localparam int unsigned NCH   = 4;
  localparam int unsigned PIX   = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned TB    = 24;
  localparam int unsigned BW    = 16 * PIX;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NCH-1:0]       in_valid;
  logic [NCH*BW-1:0]    in_data;
  logic [NCH*TB-1:0]    in_tag;
  logic                 in_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [BW-1:0]        out_data;
  logic [TB-1:0]        out_tag;
  logic                 flush;
  logic                 ovf_clr;
  logic [4:0]           level;
  logic                 overflow;
  logic [15:0]          drop_cnt;

  gg_deblock_writeback #(
    .NCH      (NCH),
    .PIX_BITS (PIX),
    .DEPTH    (DEPTH),
    .TAG_BITS (TB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .flush     (flush),
    .ovf_clr   (ovf_clr),
    .level     (level),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [TB-1:0] q[$];
  int unsigned   lvl = 0;
  int unsigned   nt  = 24'h100;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] blk_of(input logic [TB-1:0] t);
    return {8{t[15:0]}};
  endfunction

  function automatic logic [NCH*TB-1:0] seq(input int unsigned base);
    logic [NCH*TB-1:0] r;
    for (int unsigned i = 0; i < NCH; i++) r[i*TB +: TB] = TB'(base + i);
    return r;
  endfunction

  // One clock: drive, predict with a queue model, check head, advance.
  task automatic cycle(input logic [NCH-1:0] mask, input logic rdy, input logic [NCH*TB-1:0] tags);
    logic          hold;
    logic [TB-1:0] ht;
    logic [BW-1:0] hd;
    int unsigned   lvl0;
    in_valid  = mask;
    out_ready = rdy;
    in_tag    = tags;
    for (int unsigned i = 0; i < NCH; i++) in_data[i*BW +: BW] = blk_of(tags[i*TB +: TB]);
    check("out_valid", {127'd0, out_valid}, {127'd0, lvl != 0});
    hold = 1'b0;
    ht   = '0;
    hd   = '0;
    lvl0 = lvl;
    if (reset || flush) begin
      q.delete();
      lvl = 0;
    end else begin
      if (lvl0 != 0) begin
        check("head_tag", {104'd0, out_tag}, {104'd0, q[0]});
        check("head_data", out_data, blk_of(q[0]));
        if (rdy) begin
          void'(q.pop_front());
          lvl--;
        end else begin
          hold = 1'b1;
          ht   = out_tag;
          hd   = out_data;
        end
      end
      if (mask != 0 && lvl0 <= DEPTH - NCH) begin
        for (int unsigned i = 0; i < NCH; i++) begin
          if (mask[i]) begin
            q.push_back(tags[i*TB +: TB]);
            lvl++;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    in_valid  = '0;
    out_ready = 1'b0;
    if (hold) begin
      check("hold_tag", {104'd0, out_tag}, {104'd0, ht});
      check("hold_data", out_data, hd);
    end
  endtask

  function automatic logic [TB-1:0] mb_tag(input int unsigned n);
    if (n < 16) return {8'd3, 8'd5, 4'd0, 4'(n)};
    return {8'd3, 8'd5, 4'(1 + (n - 16) / 4), 4'((n - 16) % 4)};
  endfunction

  initial begin
    logic [NCH*TB-1:0] t;
    int unsigned       n;
    int unsigned       budget;
    logic              tog;

    reset = 1'b1; flush = 1'b0; ovf_clr = 1'b0;
    in_valid = '0; in_data = '0; in_tag = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_in_ready", {127'd0, in_ready}, 128'd1);
    check("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("rst_level", {123'd0, level}, 128'd0);
    check("rst_overflow", {127'd0, overflow}, 128'd0);
    check("rst_drop_cnt", {112'd0, drop_cnt}, 128'd0);

    // single channel, one-cycle latency
    t = '0; t[0 +: TB] = 24'h000001;
    cycle(4'b0001, 1'b0, t);
    check("single_level", {123'd0, level}, 128'd1);
    check("single_tag", {104'd0, out_tag}, 128'h1);
    cycle('0, 1'b1, '0);
    check("single_pop_level", {123'd0, level}, 128'd0);
    cycle('0, 1'b1, '0);
    check("empty_pop_level", {123'd0, level}, 128'd0);

    // compaction of a gappy valid vector
    t = {24'h000C, 24'hBAD, 24'h000A, 24'hBAD};
    cycle(4'b1010, 1'b0, t);
    check("compact_level", {123'd0, level}, 128'd2);
    check("compact_head", {104'd0, out_tag}, 128'hA);
    t = seq(int'(CH_ABV));
    cycle('0, 1'b1, '0);
    check("compact_second", {104'd0, out_tag}, 128'hC);
    cycle('0, 1'b1, '0);

    // fill to full, then a dropped cycle
    for (int unsigned c = 0; c < 4; c++) begin
      cycle(4'hF, 1'b0, seq(nt)); nt += 4;
      if (c == 2) check("ready_at_12", {127'd0, in_ready}, 128'd1);
    end
    check("full_level", {123'd0, level}, 128'd16);
    check("full_in_ready", {127'd0, in_ready}, 128'd0);
    cycle(4'hF, 1'b0, seq(nt)); nt += 4;
    check("drop_overflow", {127'd0, overflow}, 128'd1);
    check("drop_cnt4", {112'd0, drop_cnt}, 128'd4);
    check("drop_level", {123'd0, level}, 128'd16);

    // drain to 9 then flush
    repeat (7) cycle('0, 1'b1, '0);
    check("pre_flush_level", {123'd0, level}, 128'd9);
    flush = 1'b1;
    cycle(4'h3, 1'b1, seq(nt)); nt += 4;
    flush = 1'b0;
    check("flush_level", {123'd0, level}, 128'd0);
    check("flush_out_valid", {127'd0, out_valid}, 128'd0);
    check("flush_keeps_ovf", {127'd0, overflow}, 128'd1);
    check("flush_keeps_drop", {112'd0, drop_cnt}, 128'd4);
    ovf_clr = 1'b1;
    cycle('0, 1'b0, '0);
    ovf_clr = 1'b0;
    check("clr_overflow", {127'd0, overflow}, 128'd0);
    check("clr_drop_cnt", {112'd0, drop_cnt}, 128'd0);

    // concurrent push/pop across the wrap point (wr 14, rd 9)
    repeat (3) begin cycle(4'hF, 1'b0, seq(nt)); nt += 4; end
    cycle(4'b0011, 1'b0, seq(nt)); nt += 4;
    check("wrap_setup_level", {123'd0, level}, 128'd14);
    repeat (9) cycle('0, 1'b1, '0);
    check("wrap_level5", {123'd0, level}, 128'd5);
    cycle(4'b0111, 1'b1, seq(nt)); nt += 4;
    check("push3_pop1_level", {123'd0, level}, 128'd7);
    repeat (7) cycle('0, 1'b1, '0);
    check("wrap_drained", {123'd0, level}, 128'd0);

    // 24-block macroblock stream with toggling backpressure
    n = 0; budget = 0; tog = 1'b0;
    while ((n < 24 || lvl != 0) && budget < 200) begin
      if (n < 24 && lvl <= DEPTH - NCH) begin
        for (int unsigned i = 0; i < NCH; i++) t[i*TB +: TB] = mb_tag(n + i);
        cycle(4'hF, tog, t);
        n += 4;
      end else begin
        cycle('0, tog, '0);
      end
      tog = ~tog;
      budget++;
    end
    check("stream_budget", {127'd0, budget < 200}, 128'd1);
    check("stream_empty", {123'd0, level}, 128'd0);

    // drop coinciding with ovf_clr, then reset mid-stream
    repeat (4) begin cycle(4'hF, 1'b0, seq(nt)); nt += 4; end
    ovf_clr = 1'b1;
    cycle(4'b0011, 1'b0, seq(nt)); nt += 4;
    ovf_clr = 1'b0;
    check("clr_drop_overflow", {127'd0, overflow}, 128'd1);
    check("clr_drop_cnt2", {112'd0, drop_cnt}, 128'd2);
    repeat (7) cycle('0, 1'b1, '0);
    check("pre_reset_level", {123'd0, level}, 128'd9);
    reset = 1'b1;
    cycle('0, 1'b1, '0);
    reset = 1'b0;
    check("mid_rst_level", {123'd0, level}, 128'd0);
    check("mid_rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("mid_rst_in_ready", {127'd0, in_ready}, 128'd1);
    check("mid_rst_overflow", {127'd0, overflow}, 128'd0);
    check("mid_rst_drop_cnt", {112'd0, drop_cnt}, 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
